// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes,
// default reset vector and the RAS pointer-width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEL_HOLD,
    PC_SEL_INC,
    PC_SEL_BR,
    PC_SEL_CALL,
    PC_SEL_RET
  } pc_sel_e;

  localparam int PC_RESET_VEC = 0;

  // Index width for a power-of-two stack; never narrower than one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop on an empty stack is ignored.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_data,
  output logic [WIDTH-1:0]          o_top,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ras_ptr_w(DEPTH):0] o_count
);

  localparam int PW = ras_ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_count;
  logic [PW-1:0]    w_top_idx;

  // r_ptr is the next free slot; once full it also indexes the oldest entry.
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) r_count <= r_count + (PW+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-address register with hold/increment/branch/call/return selection.
// Define PC_RAS_EN to build the return-address stack; otherwise call is a plain branch.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_inc;
  pc_sel_e          w_sel;

  assign w_inc = r_pc + WIDTH'(STEP);
  assign pc    = r_pc;

  // Priority: stall > ret > call > branch > increment.
  always_comb begin
    w_sel = PC_SEL_INC;
    if (stall)             w_sel = PC_SEL_HOLD;
`ifdef PC_RAS_EN
    else if (ret)          w_sel = PC_SEL_RET;
`endif
    else if (call)         w_sel = PC_SEL_CALL;
    else if (branch_valid) w_sel = PC_SEL_BR;
  end

`ifdef PC_RAS_EN
  logic [WIDTH-1:0]               w_ras_top;
  logic                           w_ras_full;
  logic                           w_ras_empty;
  logic [ras_ptr_w(RAS_DEPTH):0]  w_ras_count_unused;
  logic                           w_push;
  logic                           w_pop;
  logic                           r_ovf;
  logic                           r_unf;

  assign w_push = (w_sel == PC_SEL_CALL);
  assign w_pop  = (w_sel == PC_SEL_RET) && !w_ras_empty;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty),
    .o_count (w_ras_count_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_push && w_ras_full;
      r_unf <= (w_sel == PC_SEL_RET) && w_ras_empty;
    end
  end

  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic          w_unused_ret;

  assign w_unused_ret  = ret;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    next_pc = w_inc;
    case (w_sel)
      PC_SEL_HOLD: next_pc = r_pc;
      PC_SEL_INC:  next_pc = w_inc;
      PC_SEL_BR:   next_pc = branch_target;
      PC_SEL_CALL: next_pc = branch_target;
`ifdef PC_RAS_EN
      // An empty stack falls back to the sequential address.
      PC_SEL_RET:  next_pc = w_ras_empty ? w_inc : w_ras_top;
`endif
      default:     next_pc = w_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_VEC;
    else     r_pc <= next_pc;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for the per-cycle behaviour plus a
// hand-written asynchronous-reset sequence. Expectations cover both PC_RAS_EN builds.
module tb_pc_unit;

  localparam int               WIDTH = 16;
  localparam logic [WIDTH-1:0] RVEC  = 16'h0100;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             stall;
  logic             branch_valid;
  logic [WIDTH-1:0] branch_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] next_pc;
  logic             ras_overflow;
  logic             ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(
    .WIDTH     (WIDTH),
    .RESET_VEC (RVEC),
    .STEP      (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .next_pc       (next_pc),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic             stall;
    logic             br;
    logic [WIDTH-1:0] tgt;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_ras;   // expected pc with the stack built
    logic [WIDTH-1:0] pc_nor;   // expected pc without the stack
    logic             ovf;
    logic             unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic b, input logic [WIDTH-1:0] t,
                     input logic c, input logic r, input logic [WIDTH-1:0] pr,
                     input logic [WIDTH-1:0] pn, input logic o, input logic u);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.call = c; v.ret = r;
    v.pc_ras = pr; v.pc_nor = pn; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endtask

  // Drive one cycle of requests and check next_pc before the edge, pc/flags after.
  task automatic apply(input vec_t v, input string tag);
    logic [WIDTH-1:0] exp_pc;
    exp_pc        = RAS_ON ? v.pc_ras : v.pc_nor;
    stall         = v.stall;
    branch_valid  = v.br;
    branch_target = v.tgt;
    call          = v.call;
    ret           = v.ret;
    #1;
    chk({tag, " next_pc"}, 32'(next_pc), 32'(exp_pc));
    @(posedge clk);
    #1;
    chk({tag, " pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, " ovf"}, 32'(ras_overflow), 32'(v.ovf & RAS_ON));
    chk({tag, " unf"}, 32'(ras_underflow), 32'(v.unf & RAS_ON));
  endtask

  initial begin
    vec_t v;
    rst = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    call = 1'b0; ret = 1'b0;

    //   stall br  tgt       call ret  pc_ras    pc_nor    ovf  unf
    add(0, 0, 16'h0000, 0, 0, 16'h0101, 16'h0101, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0102, 16'h0102, 0, 0);
    add(0, 1, 16'h0040, 0, 0, 16'h0040, 16'h0040, 0, 0);
    add(1, 1, 16'h0080, 0, 0, 16'h0040, 16'h0040, 0, 0);
    add(1, 1, 16'h0080, 0, 0, 16'h0040, 16'h0040, 0, 0);
    add(1, 1, 16'h0080, 0, 0, 16'h0040, 16'h0040, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0041, 16'h0041, 0, 0);
    add(0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0010, 0, 0, 16'h0010, 16'h0010, 0, 0);
    add(0, 0, 16'h0200, 1, 0, 16'h0200, 16'h0200, 0, 0);
    add(0, 0, 16'h0300, 1, 0, 16'h0300, 16'h0300, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0201, 16'h0301, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0011, 16'h0302, 0, 0);
    add(0, 0, 16'h1000, 1, 0, 16'h1000, 16'h1000, 0, 0);
    add(0, 0, 16'h2000, 1, 0, 16'h2000, 16'h2000, 0, 0);
    add(0, 0, 16'h3000, 1, 0, 16'h3000, 16'h3000, 0, 0);
    add(0, 0, 16'h4000, 1, 0, 16'h4000, 16'h4000, 0, 0);
    add(0, 0, 16'h5000, 1, 0, 16'h5000, 16'h5000, 1, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h4001, 16'h5001, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h3001, 16'h5002, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h2001, 16'h5003, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h1001, 16'h5004, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h1002, 16'h5005, 0, 1);
    add(0, 0, 16'h0000, 0, 0, 16'h1003, 16'h5006, 0, 0);
    add(0, 1, 16'h0054, 0, 0, 16'h0054, 16'h0054, 0, 0);
    add(0, 0, 16'h0800, 1, 0, 16'h0800, 16'h0800, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0800, 16'h0800, 0, 0);
    add(0, 0, 16'h0900, 1, 1, 16'h0055, 16'h0900, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0056, 16'h0901, 0, 1);
    add(0, 0, 16'h0700, 1, 0, 16'h0700, 16'h0700, 0, 0);

    // Reset state, before and across a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset pc async", 32'(pc), 32'(RVEC));
    chk("reset ovf", 32'(ras_overflow), 32'h0);
    chk("reset unf", 32'(ras_underflow), 32'h0);
    @(posedge clk);
    #1;
    chk("reset pc held", 32'(pc), 32'(RVEC));
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-cycle asynchronous reset with a pushed entry pending in the stack.
    #3 rst = 1'b1;
    #1;
    chk("midreset pc", 32'(pc), 32'(RVEC));
    chk("midreset ovf", 32'(ras_overflow), 32'h0);
    chk("midreset unf", 32'(ras_underflow), 32'h0);
    #2 rst = 1'b0;
    v.stall = 0; v.br = 0; v.tgt = '0; v.call = 0; v.ret = 1;
    v.pc_ras = 16'h0101; v.pc_nor = 16'h0101; v.ovf = 0; v.unf = 1;
    apply(v, "ret_after_reset");
    v.ret = 0; v.pc_ras = 16'h0102; v.pc_nor = 16'h0102; v.unf = 0;
    apply(v, "idle_after_unf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
